ack_bus_scheduler: RTL



---
 rtl/ack_bus_pkg.sv | 20 ++
 rtl/ack_rr_pick.sv | 33 +++
 rtl/ack_bus_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/ack_bus_pkg.sv
// Shared definitions for the acknowledge bus: source IDs, scheduler states
// and a small ID-to-one-hot helper.
package ack_bus_pkg;

  localparam logic [1:0] ID_MEM  = 2'd0;
  localparam logic [1:0] ID_SHA  = 2'd1;
  localparam logic [1:0] ID_AES  = 2'd2;
  localparam logic [1:0] ID_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/ack_rr_pick.sv
// Combinational winner picker: round-robin starting after the last winner,
// or fixed priority (lowest ID wins) when i_fixed_prio is set.
module ack_rr_pick
  import ack_bus_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_last_winner,
  input  logic       i_fixed_prio,
  output logic       o_valid,
  output logic [1:0] o_winner
);

  logic [1:0] w_idx;

  // Loops run from lowest to highest precedence so the last hit is the winner.
  always_comb begin
    o_valid  = |i_req;
    o_winner = ID_MEM;
    w_idx    = '0;
    if (i_fixed_prio) begin
      for (int i = 3; i >= 0; i--) begin
        if (i_req[i]) o_winner = 2'(i);
      end
    end else begin
      // Offsets 4..1 wrap in two bits, so offset 4 lands on the last winner itself.
      for (int k = 4; k >= 1; k--) begin
        w_idx = i_last_winner + 2'(k);
        if (i_req[w_idx]) o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/ack_bus_scheduler.sv
// Clocked round-robin / fixed-priority scheduler for the four-source
// acknowledge bus. One grant per IDLE->GRANT->RELEASE round, registered
// one-hot READY, winner ID broadcast and optional RELEASE timeout.
module ack_bus_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fixed_prio,
  input  logic       req_mem,
  input  logic       req_sha,
  input  logic       req_aes,
  input  logic       req_ctrl,
  output logic       ack_ready_to_mem,
  output logic       ack_ready_to_sha,
  output logic       ack_ready_to_aes,
  output logic       ack_ready_to_ctrl,
  output logic [1:0] winner_source_id,
  output logic       ack_event,
  output logic       busy,
  output logic       timeout_err
);
  import ack_bus_pkg::*;

  // A zero-width counter is illegal, so TIMEOUT=0 keeps a one-bit counter that never moves.
  localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [3:0]    r_ready;
  logic [1:0]    r_winner;
  logic [1:0]    r_last_winner;
  logic          r_ack_event;
  logic          r_busy;
  logic          r_timeout_err;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_req;
  logic          w_pick_vld;
  logic [1:0]    w_pick_id;
  logic          w_winner_req;

  assign w_req        = {req_ctrl, req_aes, req_sha, req_mem};
  assign w_winner_req = w_req[r_winner];

  ack_rr_pick u_pick (
    .i_req         (w_req),
    .i_last_winner (r_last_winner),
    .i_fixed_prio  (fixed_prio),
    .o_valid       (w_pick_vld),
    .o_winner      (w_pick_id)
  );

  // Scheduler FSM; every output is registered and derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ready       <= '0;
      r_winner      <= ID_MEM;
      r_last_winner <= ID_CTRL;
      r_ack_event   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_ready       <= '0;
      r_ack_event   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state       <= GRANT;
            r_winner      <= w_pick_id;
            r_last_winner <= w_pick_id;
            r_ready       <= id_to_onehot(w_pick_id);
            r_ack_event   <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        GRANT: begin
          r_state <= RELEASE;
          r_cnt   <= '0;
        end
        RELEASE: begin
          // A dropped request wins over a timeout landing on the same edge.
          if (!w_winner_req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_ready_to_mem  = r_ready[0];
  assign ack_ready_to_sha  = r_ready[1];
  assign ack_ready_to_aes  = r_ready[2];
  assign ack_ready_to_ctrl = r_ready[3];
  assign winner_source_id  = r_winner;
  assign ack_event         = r_ack_event;
  assign busy              = r_busy;
  assign timeout_err       = r_timeout_err;

endmodule
